multicycle_ctrl: RTL and testbench

Control FSM for the multi-cycle RV32I core. Sequences fetch, decode, execute, memory and writeback over one shared memory port with a req/ready/rvalid handshake. Drives the select and write-enable lines of the PC, IR, register file, ALU muxes and immediate generator, and keeps cycle and retired-instruction counters. Sits beside the datapath, between the IR and the memory interface.

---
 rtl/core_pkg.sv | 58 +++++
 rtl/ctrl_perf_cnt.sv | 37 +++
 rtl/multicycle_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared opcode constants and control enums for the
//                multi-cycle RV32I core.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  // RV32I major opcodes (ir[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_FWAIT   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXEC    = 4'd3,
    ST_MEM     = 4'd4,
    ST_MWAIT   = 4'd5,
    ST_WB      = 4'd6,
    ST_HALT    = 4'd7,
    ST_ILLEGAL = 4'd8
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  // Opcodes that execute normally (SYSTEM is handled separately as halt).
  function automatic logic opc_known(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE: opc_known = 1'b1;
      default:                                 opc_known = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_perf_cnt
//  Description : Enabled free-running performance counter; wraps naturally
//                from all-ones to zero.
//  Revision    : 1.0 - initial release
//  Ports       : clk    - clock
//                reset  - synchronous active-high clear
//                en_i   - count enable
//                cnt_o  - current count
// ============================================================================
module ctrl_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Control FSM for the multi-cycle RV32I core. Sequences
//                fetch/decode/execute/memory/writeback over one shared
//                req/ready/rvalid memory port and drives the datapath
//                selects and write enables. Keeps cycle and instret counters.
//  Revision    : 1.0 - initial release
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                ir_i                - current IR contents
//                br_taken_i          - branch comparator result (EXEC)
//                mem_ready_i         - memory accepts request this cycle
//                mem_rvalid_i        - read data valid
//                opcode_o            - ir_i[6:0] to immediate generator
//                ir_we_o, pc_we_o    - IR / PC write enables
//                pc_sel_o            - 0 PC+4, 1 PC+imm, 2 ALU & ~1
//                alu_a_sel_o         - 0 rs1, 1 PC
//                alu_b_sel_o         - 0 rs2, 1 imm
//                rf_we_o, wb_sel_o   - RF write / writeback source
//                mem_req_o, mem_we_o - memory request / write
//                mem_addr_sel_o      - 0 PC, 1 ALU result
//                retire_o            - one pulse per retired instruction
//                halt_o, illegal_o   - sticky terminal status
//                cycle_cnt_o         - active cycles since reset
//                instret_o           - retired instructions since reset
// ============================================================================
module multicycle_ctrl
  import core_pkg::*;
#(
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     ir_i,
  input  logic            br_taken_i,
  input  logic            mem_ready_i,
  input  logic            mem_rvalid_i,
  output logic [6:0]      opcode_o,
  output logic            ir_we_o,
  output logic            pc_we_o,
  output logic [1:0]      pc_sel_o,
  output logic            alu_a_sel_o,
  output logic            alu_b_sel_o,
  output logic            rf_we_o,
  output logic [1:0]      wb_sel_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            mem_addr_sel_o,
  output logic            retire_o,
  output logic            halt_o,
  output logic            illegal_o,
  output logic [CNTW-1:0] cycle_cnt_o,
  output logic [CNTW-1:0] instret_o
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;

  logic [6:0] opc;
  logic       is_branch;
  logic       is_fence;
  logic       is_load;
  logic       is_store;
  logic       alu_a_pc;
  logic       alu_b_imm;
  logic       cyc_en;
  logic       unused_ir_bits;

  assign opc       = ir_i[6:0];
  assign opcode_o  = opc;
  assign is_branch = (opc == OPC_BRANCH);
  assign is_fence  = (opc == OPC_FENCE);
  assign is_load   = (opc == OPC_LOAD);
  assign is_store  = (opc == OPC_STORE);

  // Only the opcode field is decoded here; the rest of the IR feeds the datapath.
  assign unused_ir_bits = ^ir_i[31:7];

  // PC is the A operand for PC-relative arithmetic; register-register ops
  // and branch compares are the only users of rs2 on the B side.
  assign alu_a_pc  = (opc == OPC_AUIPC) || (opc == OPC_JAL);
  assign alu_b_imm = !((opc == OPC_OP) || (opc == OPC_BRANCH));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready_i)  state_d = ST_FWAIT;
      ST_FWAIT:  if (mem_rvalid_i) state_d = ST_DECODE;
      ST_DECODE: begin
        if (opc == OPC_SYSTEM)  state_d = ST_HALT;
        else if (opc_known(opc)) state_d = ST_EXEC;
        else                     state_d = ST_ILLEGAL;
      end
      ST_EXEC: begin
        if (is_branch || is_fence)  state_d = ST_FETCH;
        else if (is_load || is_store) state_d = ST_MEM;
        else                          state_d = ST_WB;
      end
      ST_MEM:    if (mem_ready_i)  state_d = is_store ? ST_FETCH : ST_MWAIT;
      ST_MWAIT:  if (mem_rvalid_i) state_d = ST_WB;
      ST_WB:                       state_d = ST_FETCH;
      ST_HALT:                     state_d = ST_HALT;
      ST_ILLEGAL:                  state_d = ST_ILLEGAL;
      default:                     state_d = ST_ILLEGAL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. Everything is forced idle while reset is high so an
  // interrupted instruction can never write the PC or register file.
  // --------------------------------------------------------------------------
  always_comb begin
    ir_we_o        = 1'b0;
    pc_we_o        = 1'b0;
    pc_sel_o       = PC_PLUS4;
    alu_a_sel_o    = 1'b0;
    alu_b_sel_o    = 1'b0;
    rf_we_o        = 1'b0;
    wb_sel_o       = WB_ALU;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    retire_o       = 1'b0;
    halt_o         = 1'b0;
    illegal_o      = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: mem_req_o = 1'b1;
        ST_FWAIT: ir_we_o   = mem_rvalid_i;
        ST_EXEC: begin
          alu_a_sel_o = alu_a_pc;
          alu_b_sel_o = alu_b_imm;
          if (is_branch) begin
            pc_we_o  = 1'b1;
            pc_sel_o = br_taken_i ? PC_IMM : PC_PLUS4;
            retire_o = 1'b1;
          end else if (is_fence) begin
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
          end
        end
        ST_MEM: begin
          // ALU selects held so the address stays stable until acceptance
          alu_a_sel_o    = alu_a_pc;
          alu_b_sel_o    = alu_b_imm;
          mem_req_o      = 1'b1;
          mem_addr_sel_o = 1'b1;
          mem_we_o       = is_store;
          if (is_store && mem_ready_i) begin
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
          end
        end
        ST_MWAIT: begin
          alu_a_sel_o = alu_a_pc;
          alu_b_sel_o = alu_b_imm;
          wb_sel_o    = WB_MEM;
        end
        ST_WB: begin
          alu_a_sel_o = alu_a_pc;
          alu_b_sel_o = alu_b_imm;
          rf_we_o     = 1'b1;
          pc_we_o     = 1'b1;
          retire_o    = 1'b1;
          case (opc)
            OPC_JAL: begin
              wb_sel_o = WB_PC4;
              pc_sel_o = PC_IMM;
            end
            OPC_JALR: begin
              wb_sel_o = WB_PC4;
              pc_sel_o = PC_ALU;
            end
            OPC_LUI:  wb_sel_o = WB_IMM;
            OPC_LOAD: wb_sel_o = WB_MEM;
            default:  wb_sel_o = WB_ALU;
          endcase
        end
        ST_HALT:    halt_o    = 1'b1;
        ST_ILLEGAL: illegal_o = 1'b1;
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  assign cyc_en = (state_q != ST_HALT) && (state_q != ST_ILLEGAL);

  ctrl_perf_cnt #(.W(CNTW)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en_i  (cyc_en),
    .cnt_o (cycle_cnt_o)
  );

  ctrl_perf_cnt #(.W(CNTW)) u_instret_cnt (
    .clk   (clk),
    .reset (reset),
    .en_i  (retire_o),
    .cnt_o (instret_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. A memory responder
//                with configurable wait/latency drives the handshake; each
//                instruction's cycle count, strobes and counters are compared
//                against expectations derived from its instruction class.
//                A second instance with 4-bit counters checks wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111,
    O_JAL = 7'b1101111, O_JALR = 7'b1100111, O_BR = 7'b1100011,
    O_LD = 7'b0000011, O_ST = 7'b0100011, O_OPI = 7'b0010011,
    O_OP = 7'b0110011, O_FEN = 7'b0001111, O_SYS = 7'b1110011;

  localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_BR = 3, C_FEN = 4,
    C_SYS = 5, C_BAD = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_i;
  logic        br_taken_i, mem_ready_i, mem_rvalid_i;

  logic [6:0]  opcode_o;
  logic        ir_we_o, pc_we_o, alu_a_sel_o, alu_b_sel_o, rf_we_o;
  logic [1:0]  pc_sel_o, wb_sel_o;
  logic        mem_req_o, mem_we_o, mem_addr_sel_o, retire_o, halt_o, illegal_o;
  logic [31:0] cycle_cnt_o, instret_o;

  logic [6:0]  s_opcode;
  logic        s_ir_we, s_pc_we, s_a, s_b, s_rf_we, s_req, s_we, s_as, s_ret, s_h, s_i;
  logic [1:0]  s_pcs, s_wbs;
  logic [3:0]  cyc4, ret4;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNTW(32)) dut (
    .clk(clk), .reset(reset), .ir_i(ir_i), .br_taken_i(br_taken_i),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
    .opcode_o(opcode_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o),
    .pc_sel_o(pc_sel_o), .alu_a_sel_o(alu_a_sel_o), .alu_b_sel_o(alu_b_sel_o),
    .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_sel_o(mem_addr_sel_o), .retire_o(retire_o),
    .halt_o(halt_o), .illegal_o(illegal_o), .cycle_cnt_o(cycle_cnt_o),
    .instret_o(instret_o)
  );

  multicycle_ctrl #(.CNTW(4)) dut4 (
    .clk(clk), .reset(reset), .ir_i(ir_i), .br_taken_i(br_taken_i),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
    .opcode_o(s_opcode), .ir_we_o(s_ir_we), .pc_we_o(s_pc_we),
    .pc_sel_o(s_pcs), .alu_a_sel_o(s_a), .alu_b_sel_o(s_b),
    .rf_we_o(s_rf_we), .wb_sel_o(s_wbs), .mem_req_o(s_req),
    .mem_we_o(s_we), .mem_addr_sel_o(s_as), .retire_o(s_ret),
    .halt_o(s_h), .illegal_o(s_i), .cycle_cnt_o(cyc4), .instret_o(ret4)
  );

  int ncmp = 0;
  int nfail = 0;
  longint unsigned m_cyc = 0;
  longint unsigned m_ret = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_cycle_cnt"},  64'(cycle_cnt_o), m_cyc & 64'hFFFF_FFFF);
    chk({tag, "_instret"},    64'(instret_o),   m_ret & 64'hFFFF_FFFF);
    chk({tag, "_cycle_cnt4"}, 64'(cyc4),        m_cyc & 64'hF);
    chk({tag, "_instret4"},   64'(ret4),        m_ret & 64'hF);
  endtask

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      O_OP, O_OPI, O_LUI, O_AUIPC, O_JAL, O_JALR: return C_ALU;
      O_LD:  return C_LD;
      O_ST:  return C_ST;
      O_BR:  return C_BR;
      O_FEN: return C_FEN;
      O_SYS: return C_SYS;
      default: return C_BAD;
    endcase
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_mem_req", 64'(mem_req_o), 0);
    chk("rst_strobes", 64'({ir_we_o, pc_we_o, rf_we_o, retire_o, mem_we_o}), 0);
    chk("rst_status", 64'({halt_o, illegal_o}), 0);
    m_cyc = 0; m_ret = 0;
    chk_counters("rst");
    reset = 1'b0; #1;
    chk("post_rst_mem_req", 64'(mem_req_o), 1);
  endtask

  // Runs one instruction. fw/mw: cycles the memory holds ready low for the
  // fetch/data request; fl/ml: cycles from acceptance to rvalid (>=1).
  task automatic run_instr(input logic [31:0] ir, input logic br,
                           input int fw, input int fl, input int mw, input int ml,
                           input bit abort);
    int  c, fetch, exp_cyc, exp_wb, exp_pcs;
    bit  exp_rf, exp_ret;
    int  cycles = 0, ir_n = 0, rf_n = 0, pc_n = 0, req_idx = 0, waited = 0, cd = 0;
    int  wb_seen = -1, pcs_seen = -1;
    bit  pending = 0, done = 0, retired = 0, term = 0, aborted = 0;
    bit  fa_or = 0, da_and = 1, we_or = 0, dreq = 0;
    logic [6:0] op;

    op = ir[6:0];
    c  = cls_of(op);
    fetch = 1 + fw + fl;
    case (c)
      C_ALU:        exp_cyc = fetch + 3;
      C_LD:         exp_cyc = fetch + 4 + mw + ml;
      C_ST:         exp_cyc = fetch + 3 + mw;
      default:      exp_cyc = fetch + 2;
    endcase
    exp_rf  = (c == C_ALU) || (c == C_LD);
    exp_ret = (c != C_SYS) && (c != C_BAD);
    exp_wb  = (op == O_JAL || op == O_JALR) ? 2 : (op == O_LUI) ? 3 : (c == C_LD) ? 1 : 0;
    exp_pcs = (op == O_JAL) ? 1 : (op == O_JALR) ? 2 : (c == C_BR) ? int'(br) : 0;

    ir_i = ir; br_taken_i = br;
    for (int k = 0; k < 300 && !done; k++) begin
      mem_ready_i = 1'b0;
      if (pending) mem_rvalid_i = (cd == 0);
      else         mem_rvalid_i = ($urandom_range(0, 3) == 0);
      if (mem_req_o && waited == ((req_idx == 0) ? fw : mw)) mem_ready_i = 1'b1;
      #1;
      cycles++;
      if (ir_we_o) ir_n++;
      if (rf_we_o) begin rf_n++; wb_seen = int'(wb_sel_o); end
      if (pc_we_o) begin pc_n++; pcs_seen = int'(pc_sel_o); end
      if (mem_req_o) begin
        if (req_idx == 0) fa_or = fa_or | mem_addr_sel_o;
        else begin da_and = da_and & mem_addr_sel_o; dreq = 1; end
        we_or = we_or | mem_we_o;
      end
      if (pending) begin
        if (cd == 0) pending = 0;
        else         cd--;
      end
      if (mem_req_o) begin
        if (mem_ready_i) begin
          if (!mem_we_o) begin
            pending = 1;
            cd = ((req_idx == 0) ? fl : ml) - 1;
          end
          if (abort && req_idx == 1) begin aborted = 1; done = 1; end
          req_idx++;
          waited = 0;
        end else waited++;
      end
      if (retire_o) begin retired = 1; done = 1; end
      if (halt_o || illegal_o) begin term = 1; done = 1; end
      if (!done) @(negedge clk);
    end

    chk("finished", 64'(done), 1);
    if (aborted) begin
      chk("abort_pre_rf_we", 64'(rf_n), 0);
      return;
    end
    chk("cycles", 64'(cycles), 64'(exp_cyc));
    chk("ir_we_pulses", 64'(ir_n), 1);
    chk("rf_we_pulses", 64'(rf_n), 64'(exp_rf));
    chk("pc_we_pulses", 64'(pc_n), 64'(exp_ret));
    if (exp_rf)  chk("wb_sel", 64'(wb_seen), 64'(exp_wb));
    if (exp_ret) chk("pc_sel", 64'(pcs_seen), 64'(exp_pcs));
    chk("fetch_addr_sel", 64'(fa_or), 0);
    if (dreq) chk("data_addr_sel", 64'(da_and), 1);
    chk("data_req_seen", 64'(dreq), 64'((c == C_LD) || (c == C_ST)));
    chk("mem_we", 64'(we_or), 64'(c == C_ST));
    if (c == C_SYS) chk("halt_o", 64'({halt_o, illegal_o}), 64'(2'b10));
    if (c == C_BAD) chk("illegal_o", 64'({halt_o, illegal_o}), 64'(2'b01));

    if (exp_ret) begin
      m_cyc += longint'(cycles);
      m_ret += 1;
    end else begin
      m_cyc += longint'(cycles - 1);
    end
    @(negedge clk);
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
    #1;
    chk_counters("instr");
    if (term) begin
      repeat (4) @(negedge clk);
      #1;
      chk("term_status", 64'({halt_o, illegal_o}), (c == C_SYS) ? 64'(2'b10) : 64'(2'b01));
      chk("term_no_req", 64'({mem_req_o, rf_we_o, pc_we_o}), 0);
      chk_counters("frozen");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0]  ops [10];
    logic [31:0] rir;
    ops = '{O_OP, O_OPI, O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_FEN};
    ir_i = 32'h0; br_taken_i = 1'b0;

    do_reset(3);
    run_instr(32'h002081B3, 1'b0, 0, 1, 0, 1, 1'b0);   // ADD
    run_instr(32'h0000A103, 1'b0, 0, 1, 2, 1, 1'b0);   // LW, 2 wait cycles in MEM
    run_instr(32'h00208463, 1'b1, 0, 1, 0, 1, 1'b0);   // BEQ taken
    run_instr(32'h00208463, 1'b0, 0, 1, 0, 1, 1'b0);   // BEQ not taken
    run_instr(32'h000080E7, 1'b0, 0, 1, 0, 1, 1'b0);   // JALR
    run_instr(32'h00000073, 1'b0, 0, 1, 0, 1, 1'b0);   // ECALL -> halt
    do_reset(2);
    run_instr(32'h0000007F, 1'b0, 0, 1, 0, 1, 1'b0);   // illegal opcode
    do_reset(1);

    for (int n = 0; n < 40; n++) begin
      rir = $urandom;
      rir[6:0] = ops[$urandom_range(0, 9)];
      run_instr(rir, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(1, 3), 1'b0);
    end

    // Reset while waiting for load data: response arrives during reset and
    // must not produce any writeback.
    run_instr(32'h0000A103, 1'b0, 0, 1, 0, 2, 1'b1);
    @(negedge clk);
    reset = 1'b1; mem_rvalid_i = 1'b1; mem_ready_i = 1'b0;
    #1;
    chk("abort_c1_writes", 64'({rf_we_o, pc_we_o, retire_o}), 0);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1;
    chk("abort_c2_writes", 64'({rf_we_o, pc_we_o, retire_o}), 0);
    @(negedge clk);
    reset = 1'b0; m_cyc = 0; m_ret = 0;
    #1;
    chk("abort_refetch", 64'(mem_req_o), 1);
    chk_counters("abort");
    run_instr(32'h002081B3, 1'b0, 1, 2, 0, 1, 1'b0);   // recovery ADD

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
